instr_executor: RTL

Sequential execution unit reading the instruction register. On a start pulse it walks a contiguous, wrapping range of register addresses and fetches each `instruction_t` through the register's read port. It executes the opcode, including an iterative DIV/MOD, and returns one result per instruction on a valid/ready stream. It sits downstream of the instruction register, as the consumer of what the testbench or host writes.

---
 rtl/instr_register_pkg.sv | 31 +++
 rtl/instr_executor_if.sv | 23 ++
 rtl/instr_exec_divider.sv | 95 +++++++++
 rtl/instr_executor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor.
// Provides opcode/operand/address/instruction types, the 64-bit result type,
// the executor state enum, the address wrap constant and a sign-extend helper.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        StIdle, StFetch, StExec, StDivide, StOutput
    } exec_state_t;

    localparam int unsigned ADDR_WRAP = 32;

    function automatic result_t sext(input operand_t v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/instr_executor_if.sv
// Result stream between the executor and its consumer.
//   master: drives res_valid/res_data/res_opc/res_addr/res_err, samples res_ready
//   slave : the consumer side
interface instr_executor_if;
    import instr_register_pkg::*;

    logic     res_valid;
    logic     res_ready;
    result_t  res_data;
    opcode_t  res_opc;
    address_t res_addr;
    logic     res_err;

    modport master (
        output res_valid, res_data, res_opc, res_addr, res_err,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_data, res_opc, res_addr, res_err,
        output res_ready
    );
endinterface

// File: rtl/instr_exec_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit
// per cycle, NUM_STEPS cycles after i_start.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset (discards work)
//   i_start         : load operands and begin
//   i_dividend/i_divisor : signed operands (divisor must be nonzero)
//   i_is_mod        : 1 returns remainder, 0 returns quotient
//   o_done          : high during the final step; o_result is valid then
//   o_result        : sign-corrected, sign-extended 64-bit result
module instr_exec_divider
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 32
) (
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_start,
    input  operand_t i_dividend,
    input  operand_t i_divisor,
    input  logic     i_is_mod,
    output logic     o_done,
    output result_t  o_result
);
    localparam int unsigned CntW = $clog2(NUM_STEPS) + 1;

    logic            r_active;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_quo;
    logic [31:0]     r_rem;
    logic [31:0]     r_dvs;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_mod;

    logic [32:0]     w_shift;
    logic [32:0]     w_diff;
    logic            w_qbit;
    logic [31:0]     w_quo_next;
    logic [31:0]     w_rem_next;
    logic [63:0]     w_q_mag;
    logic [63:0]     w_r_mag;

    // Magnitude as unsigned, so -2^31 maps to 0x8000_0000 without overflow.
    function automatic logic [31:0] mag(input operand_t v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        w_shift    = {r_rem, r_quo[31]};
        w_diff     = w_shift - {1'b0, r_dvs};
        w_qbit     = ~w_diff[32];
        w_rem_next = w_qbit ? w_diff[31:0] : w_shift[31:0];
        w_quo_next = {r_quo[30:0], w_qbit};
        w_q_mag    = {32'd0, w_quo_next};
        w_r_mag    = {32'd0, w_rem_next};
        // Result is taken from the final step's next-state values so the caller
        // can register it on the same edge the last bit is produced.
        if (r_is_mod) begin
            o_result = r_neg_r ? -w_r_mag : w_r_mag;
        end else begin
            o_result = r_neg_q ? -w_q_mag : w_q_mag;
        end
        o_done = r_active && (r_cnt == CntW'(NUM_STEPS - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_mod <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_quo    <= mag(i_dividend);
            r_rem    <= '0;
            r_dvs    <= mag(i_divisor);
            r_neg_q  <= i_dividend[31] ^ i_divisor[31];
            r_neg_r  <= i_dividend[31];
            r_is_mod <= i_is_mod;
        end else if (r_active) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CntW'(1);
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_executor.sv
// Sequential execution unit: on i_start walks a wrapping address range of the
// instruction register, executes each instruction and streams one result each.
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_start, i_start_addr, i_count : run request (sampled only when idle)
//   o_read_pointer       : read address into the instruction register
//   i_instruction_word   : combinational read data for o_read_pointer
//   res_if (master)      : result valid/ready stream
//   o_busy, o_done       : not-idle flag, one-cycle completion pulse
// Build option: define INSTR_EXEC_DIV_EN to build the iterative DIV/MOD unit;
// otherwise DIV/MOD report an error like undefined opcodes.
module instr_executor
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  address_t         i_start_addr,
    input  logic [5:0]       i_count,
    output address_t         o_read_pointer,
    input  instruction_t     i_instruction_word,
    instr_executor_if.master res_if,
    output logic             o_busy,
    output logic             o_done
);
    exec_state_t  r_state;
    exec_state_t  w_state_next;
    address_t     r_ptr;
    logic [5:0]   r_remain;
    instruction_t r_instr;
    logic         r_res_valid;
    result_t      r_res_data;
    opcode_t      r_res_opc;
    address_t     r_res_addr;
    logic         r_res_err;
    logic         r_done;

    result_t      w_exec_data;
    logic         w_exec_err;
    logic         w_exec_div;
    logic         w_transfer;
    logic         w_last;

`ifdef INSTR_EXEC_DIV_EN
    logic    w_div_start;
    logic    w_div_done;
    result_t w_div_result;

    assign w_div_start = (r_state == StExec) && w_exec_div;

    instr_exec_divider #(
        .NUM_STEPS (NUM_STEPS)
    ) u_divider (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_div_start),
        .i_dividend (r_instr.op_a),
        .i_divisor  (r_instr.op_b),
        .i_is_mod   (r_instr.opc == MOD),
        .o_done     (w_div_done),
        .o_result   (w_div_result)
    );
`else
    logic w_unused_steps;
    assign w_unused_steps = ^NUM_STEPS;
`endif

    assign w_transfer = r_res_valid && res_if.res_ready;
    assign w_last     = (r_remain == 6'd1);

    // Single-cycle opcode decode on the captured instruction.
    always_comb begin
        w_exec_data = '0;
        w_exec_err  = 1'b0;
        w_exec_div  = 1'b0;
        case (r_instr.opc)
            ZERO:  w_exec_data = '0;
            PASSA: w_exec_data = sext(r_instr.op_a);
            PASSB: w_exec_data = sext(r_instr.op_b);
            ADD:   w_exec_data = sext(r_instr.op_a) + sext(r_instr.op_b);
            SUB:   w_exec_data = sext(r_instr.op_a) - sext(r_instr.op_b);
            MULT:  w_exec_data = sext(r_instr.op_a) * sext(r_instr.op_b);
`ifdef INSTR_EXEC_DIV_EN
            DIV, MOD: begin
                if (r_instr.op_b != '0) begin
                    w_exec_div = 1'b1;
                end else begin
                    w_exec_err = 1'b1;
                end
            end
`endif
            default: w_exec_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start && (i_count != '0)) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: w_state_next = StExec;
            StExec:  w_state_next = w_exec_div ? StDivide : StOutput;
`ifdef INSTR_EXEC_DIV_EN
            StDivide: begin
                if (w_div_done) begin
                    w_state_next = StOutput;
                end
            end
`else
            StDivide: w_state_next = StIdle;
`endif
            StOutput: begin
                if (w_transfer) begin
                    w_state_next = w_last ? StIdle : StFetch;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy           = (r_state != StIdle);
        o_done           = r_done;
        o_read_pointer   = r_ptr;
        res_if.res_valid = r_res_valid;
        res_if.res_data  = r_res_data;
        res_if.res_opc   = r_res_opc;
        res_if.res_addr  = r_res_addr;
        res_if.res_err   = r_res_err;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr       <= '0;
            r_remain    <= '0;
            r_instr     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_opc   <= ZERO;
            r_res_addr  <= '0;
            r_res_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (i_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ptr    <= i_start_addr;
                            r_remain <= i_count;
                        end
                    end
                end
                StFetch: r_instr <= i_instruction_word;
                StExec: begin
                    if (!w_exec_div) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_exec_data;
                        r_res_opc   <= r_instr.opc;
                        r_res_addr  <= r_ptr;
                        r_res_err   <= w_exec_err;
                    end
                end
`ifdef INSTR_EXEC_DIV_EN
                StDivide: begin
                    if (w_div_done) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_div_result;
                        r_res_opc   <= r_instr.opc;
                        r_res_addr  <= r_ptr;
                        r_res_err   <= 1'b0;
                    end
                end
`endif
                StOutput: begin
                    if (w_transfer) begin
                        r_res_valid <= 1'b0;
                        r_remain    <= r_remain - 6'd1;
                        if (w_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ptr <= address_t'((int'(r_ptr) + 1) % ADDR_WRAP);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
